// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
//
// Owns the fetch PC, which addresses a combinational instruction memory
// that returns the word in the same cycle. The fetched word and its PC are
// registered into the IF/ID pipeline register. The stage applies stall,
// branch/jump redirect, exception entry and ERET return. It also flags
// fetch address faults (AdEL) downstream so that CP0 can take them later.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset (0 = asserted)
//   stall        in   hazard stall from ID; freezes PC and IF/ID
//   redirect     in   branch taken / jump resolved in ID
//   redirect_pc  in   [31:0] target for redirect
//   exc_req      in   exception/interrupt taken by CP0 this cycle
//   eret         in   ERET in ID is committing
//   epc          in   [31:0] return address from CP0
//   pc           out  [31:0] current fetch PC, to instruction memory
//   instr_in     in   [31:0] instruction word for pc
//   if_id_instr  out  [31:0] registered instruction (0 = nop on flush/fault)
//   if_id_pc     out  [31:0] registered PC of that instruction
//   if_id_pc8    out  [31:0] if_id_pc + 8 (link address)
//   if_id_valid  out  IF/ID holds a real fetched instruction
//   if_id_exc    out  fetch AdEL fault on the registered instruction
//
// Flow control: there is no valid/ready pair on this stage. stall acts as
// an inverted "ready" from ID. While stall is high, IF/ID and pc hold, and
// any redirect is ignored, because ID re-presents it on the cycle the stall
// drops. exc_req and eret are commands, not handshakes: they always win.
// Both of them override stall.

module fetch_stage #(
  parameter logic [31:0] TEXT_BASE    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned IM_WORDS     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        if_id_exc
);

  // One past the last legal fetch byte. This is computed in 33 bits, so a
  // text segment that ends exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_BASE} + (33'(IM_WORDS) << 2);

  logic        fault;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] ifpc_nxt;
  logic        valid_nxt;
  logic        exc_nxt;

  assign fault = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || ({1'b0, pc} >= TEXT_END);

  assign if_id_pc8 = if_id_pc + 32'd8;

  // Next-state logic. The rule order is: exception, ERET, stall, redirect,
  // then sequential fetch.
  always_comb begin
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    ifpc_nxt  = if_id_pc;
    valid_nxt = if_id_valid;
    exc_nxt   = if_id_exc;
    if (exc_req || eret) begin
      // Flush IF/ID. The recorded PC is kept, and no fault is recorded,
      // even if the current pc is bad.
      pc_nxt    = exc_req ? HANDLER_ADDR : epc;
      instr_nxt = 32'd0;
      valid_nxt = 1'b0;
      exc_nxt   = 1'b0;
    end else if (!stall) begin
      // Redirect and sequential fetch both latch the current fetch. Under a
      // redirect, that fetch is the delay slot. A faulting fetch becomes a
      // nop with its PC kept for EPC/BadVAddr.
      pc_nxt    = redirect ? redirect_pc : pc + 32'd4;
      instr_nxt = fault ? 32'd0 : instr_in;
      ifpc_nxt  = pc;
      valid_nxt = 1'b1;
      exc_nxt   = fault;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= TEXT_BASE;
      if_id_instr <= 32'd0;
      if_id_pc    <= TEXT_BASE;
      if_id_valid <= 1'b0;
      if_id_exc   <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc    <= ifpc_nxt;
      if_id_valid <= valid_nxt;
      if_id_exc   <= exc_nxt;
    end
  end

endmodule
